wb_ctrl: RTL and testbench

//  Write-back controller driving the register-file write port (we/waddr/wdata).

---
 rtl/wb_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_wb_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ctrl
//  Purpose  : Write-back controller for the register-file write port.
//             Merges single-cycle ALU results with multi-cycle, in-order
//             load responses held in a small circular queue, and keeps a
//             scoreboard of registers with loads in flight so decode can
//             be stalled on RAW/WAW hazards.
//  Ports    : clk, rst                  - clock / sync active-high reset
//             alu_we_i/waddr_i/wdata_i  - ALU result
//             ld_issue_i/ld_rd_i        - load issue (allocates an entry)
//             ld_ready_o                - queue not full
//             ld_rsp_valid_i/data_i     - in-order load response
//             re1_i/raddr1_i, re2_i/raddr2_i, rd_chk_i/rd_i - decode probes
//             stall_o                   - hazard against a pending load
//             we_o/waddr_o/wdata_o      - registered register-file write
//  Config   : WB_BYPASS_EN - a load write currently on we_o no longer
//             counts as busy for stall_o (register file forwards it).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_ctrl #(
    parameter int LD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_we_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_rd_i,
    output logic        ld_ready_o,
    input  logic        ld_rsp_valid_i,
    input  logic [31:0] ld_rsp_data_i,
    input  logic        re1_i,
    input  logic [4:0]  raddr1_i,
    input  logic        re2_i,
    input  logic [4:0]  raddr2_i,
    input  logic        rd_chk_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam logic [PW:0] c_DEPTH = (PW+1)'(LD_DEPTH);
    localparam logic [PW:0] c_ONE   = (PW+1)'(1);

    // Queue storage
    logic [4:0]  r_q_rd     [LD_DEPTH];
    logic [31:0] r_q_data   [LD_DEPTH];
    logic        r_q_filled [LD_DEPTH];

    // Pointers carry one extra wrap bit so fill==tail is unambiguous
    // even when every entry is allocated.
    logic [PW:0] r_tail;
    logic [PW:0] r_fill;
    logic [PW:0] r_head;
    logic [PW:0] r_count;

    logic [31:0] r_busy;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_wb_ld;   // current we_o write came from a load

    logic [PW-1:0] w_tail_idx;
    logic [PW-1:0] w_fill_idx;
    logic [PW-1:0] w_head_idx;
    logic          w_issue;
    logic          w_rsp;
    logic          w_alu;
    logic          w_head_valid;
    logic          w_retire;
    logic [4:0]    w_ret_rd;
    logic [31:0]   w_ret_data;
    logic [31:0]   w_busy_nxt;
    logic [31:0]   w_busy_eff;

    assign w_tail_idx = r_tail[PW-1:0];
    assign w_fill_idx = r_fill[PW-1:0];
    assign w_head_idx = r_head[PW-1:0];

    assign ld_ready_o = (r_count != c_DEPTH);
    assign w_issue    = ld_issue_i && ld_ready_o;
    // Only entries allocated before this cycle may be filled.
    assign w_rsp      = ld_rsp_valid_i && (r_fill != r_tail);
    assign w_alu      = alu_we_i && (alu_waddr_i != 5'd0);

    // A response landing on the head entry can retire in the same cycle,
    // giving a one-cycle response-to-we_o latency.
    assign w_head_valid = (r_count != '0) &&
                          (r_q_filled[w_head_idx] || (w_rsp && (r_fill == r_head)));
    assign w_retire     = !w_alu && w_head_valid;
    assign w_ret_rd     = r_q_rd[w_head_idx];
    assign w_ret_data   = r_q_filled[w_head_idx] ? r_q_data[w_head_idx] : ld_rsp_data_i;

    // Clear happens first so a new load to the register just written
    // (possible with bypass) keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we && r_wb_ld) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (w_issue && (ld_rd_i != 5'd0)) begin
            w_busy_nxt[ld_rd_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_eff = r_busy;
`ifdef WB_BYPASS_EN
        if (r_we && r_wb_ld) begin
            w_busy_eff[r_waddr] = 1'b0;
        end
`endif
        w_busy_eff[0] = 1'b0;
    end

    assign stall_o = (re1_i    && w_busy_eff[raddr1_i]) |
                     (re2_i    && w_busy_eff[raddr2_i]) |
                     (rd_chk_i && w_busy_eff[rd_i]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail  <= '0;
            r_fill  <= '0;
            r_head  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
            r_wb_ld <= 1'b0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                r_q_filled[i] <= 1'b0;
            end
        end else begin
            if (w_issue) begin
                r_q_rd[w_tail_idx]     <= ld_rd_i;
                r_q_filled[w_tail_idx] <= 1'b0;
                r_tail                 <= r_tail + c_ONE;
            end
            if (w_rsp) begin
                r_q_data[w_fill_idx]   <= ld_rsp_data_i;
                r_q_filled[w_fill_idx] <= 1'b1;
                r_fill                 <= r_fill + c_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + c_ONE;
            end

            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            r_busy <= w_busy_nxt;

            if (w_alu) begin
                r_we    <= 1'b1;
                r_waddr <= alu_waddr_i;
                r_wdata <= alu_wdata_i;
                r_wb_ld <= 1'b0;
            end else if (w_retire && (w_ret_rd != 5'd0)) begin
                r_we    <= 1'b1;
                r_waddr <= w_ret_rd;
                r_wdata <= w_ret_data;
                r_wb_ld <= 1'b1;
            end else begin
                // x0 loads retire silently; address/data hold.
                r_we    <= 1'b0;
                r_wb_ld <= 1'b0;
            end
        end
    end

    assign we_o    = r_we;
    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_ctrl
//  Purpose  : Directed self-checking bench for wb_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we_i;
    logic [4:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        ld_issue_i;
    logic [4:0]  ld_rd_i;
    logic        ld_ready_o;
    logic        ld_rsp_valid_i;
    logic [31:0] ld_rsp_data_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic        rd_chk_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int n_assert = 0;
    int n_fail   = 0;

    wb_ctrl #(.LD_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_we_i       (alu_we_i),
        .alu_waddr_i    (alu_waddr_i),
        .alu_wdata_i    (alu_wdata_i),
        .ld_issue_i     (ld_issue_i),
        .ld_rd_i        (ld_rd_i),
        .ld_ready_o     (ld_ready_o),
        .ld_rsp_valid_i (ld_rsp_valid_i),
        .ld_rsp_data_i  (ld_rsp_data_i),
        .re1_i          (re1_i),
        .raddr1_i       (raddr1_i),
        .re2_i          (re2_i),
        .raddr2_i       (raddr2_i),
        .rd_chk_i       (rd_chk_i),
        .rd_i           (rd_i),
        .stall_o        (stall_o),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(we_o), 32'(we));
        chk({tag, ".waddr"}, 32'(waddr_o), 32'(a));
        chk({tag, ".wdata"}, wdata_o, d);
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue_i = 1'b1;
        ld_rd_i    = rd;
        tick();
        ld_issue_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = d;
        tick();
        ld_rsp_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_we_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
        ld_issue_i = 1'b0; ld_rd_i = '0;
        ld_rsp_valid_i = 1'b0; ld_rsp_data_i = '0;
        re1_i = 1'b0; raddr1_i = '0; re2_i = 1'b0; raddr2_i = '0;
        rd_chk_i = 1'b0; rd_i = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.ld_ready", 32'(ld_ready_o), 32'd1);
        chk("reset.stall", 32'(stall_o), 32'd0);

        // 1. ALU write x5 = 0x1234
        alu_we_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'h1234;
        tick();
        alu_we_i = 1'b0;
        chk_wr("alu_x5", 1'b1, 5'd5, 32'h1234);
        tick();
        chk_wr("alu_x5_idle", 1'b0, 5'd5, 32'h1234);

        // ALU write to x0 is not a write
        alu_we_i = 1'b1; alu_waddr_i = 5'd0; alu_wdata_i = 32'h9999;
        tick();
        alu_we_i = 1'b0;
        chk_wr("alu_x0", 1'b0, 5'd5, 32'h1234);

        // 2. Load x7 with re1 watching x7
        re1_i = 1'b1; raddr1_i = 5'd7;
        #1;
        chk("ld7.stall_pre", 32'(stall_o), 32'd0);
        issue(5'd7);
        chk("ld7.stall_issue1", 32'(stall_o), 32'd1);
        tick(); tick();
        chk("ld7.stall_wait", 32'(stall_o), 32'd1);
        respond(32'hDEADBEEF);
        chk_wr("ld7", 1'b1, 5'd7, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        chk("ld7.stall_during_we", 32'(stall_o), 32'd0);
`else
        chk("ld7.stall_during_we", 32'(stall_o), 32'd1);
`endif
        tick();
        chk("ld7.we_fall", 32'(we_o), 32'd0);
        chk("ld7.stall_after", 32'(stall_o), 32'd0);
        re1_i = 1'b0;

        // 3. Fill the queue with x1..x4, 5th issue ignored
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i));
        end
        chk("full.ld_ready", 32'(ld_ready_o), 32'd0);
        issue(5'd5);
        chk("full.ld_ready_after5", 32'(ld_ready_o), 32'd0);
        re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b1; raddr2_i = 5'd3;
        #1;
        chk("full.stall_mix", 32'(stall_o), 32'd1);
        re2_i = 1'b0;
        #1;
        chk("full.x5_not_busy", 32'(stall_o), 32'd0);
        re1_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            respond(32'(i * 32'h11));
            chk_wr($sformatf("order_x%0d", i), 1'b1, 5'(i), 32'(i * 32'h11));
            chk($sformatf("order_ready_%0d", i), 32'(ld_ready_o), 32'd1);
        end
        tick();
        chk("order.idle_we", 32'(we_o), 32'd0);
        rd_chk_i = 1'b1; rd_i = 5'd4;
        #1;
        chk("order.x4_clear", 32'(stall_o), 32'd0);
        rd_chk_i = 1'b0;

        // 4. ALU priority over a ready load
        issue(5'd8);
        alu_we_i = 1'b1; alu_waddr_i = 5'd9; alu_wdata_i = 32'h5;
        respond(32'h77);
        alu_we_i = 1'b0;
        chk_wr("prio.alu", 1'b1, 5'd9, 32'h5);
        tick();
        chk_wr("prio.load", 1'b1, 5'd8, 32'h77);
        tick();
        chk("prio.idle", 32'(we_o), 32'd0);

        // 5. Load to x0, then a stray response with an empty queue
        issue(5'd0);
        rd_chk_i = 1'b1; rd_i = 5'd0;
        #1;
        chk("x0.stall", 32'(stall_o), 32'd0);
        rd_chk_i = 1'b0;
        respond(32'hAA);
        chk_wr("x0.no_we", 1'b0, 5'd8, 32'h77);
        respond(32'hBB);
        chk_wr("stray.no_we", 1'b0, 5'd8, 32'h77);
        tick();
        chk("stray.no_we2", 32'(we_o), 32'd0);
        // Count back at 0: exactly four more issues fill the queue
        issue(5'd10); issue(5'd11); issue(5'd12);
        chk("cnt.three", 32'(ld_ready_o), 32'd1);
        issue(5'd13);
        chk("cnt.four", 32'(ld_ready_o), 32'd0);

        // 6. Reset with loads outstanding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re1_i = 1'b1; raddr1_i = 5'd10; re2_i = 1'b1; raddr2_i = 5'd13;
        #1;
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.ld_ready", 32'(ld_ready_o), 32'd1);
        chk_wr("rst.out", 1'b0, 5'd0, 32'd0);
        re1_i = 1'b0; re2_i = 1'b0;
        respond(32'h1010);
        chk("rst.rsp1_we", 32'(we_o), 32'd0);
        respond(32'h1111);
        chk("rst.rsp2_we", 32'(we_o), 32'd0);
        // Fresh load after reset retires with its own data
        issue(5'd14);
        respond(32'h1414);
        chk_wr("post_rst.x14", 1'b1, 5'd14, 32'h1414);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
